// File: rtl/alu_issue_stage.sv
// alu_issue_stage: ID/EX register in front of the 32-bit ALU.
// It resolves the operands with EX/MEM and MEM/WB forwarding, extends
// and selects the immediate, decodes the 4-bit ALU control code, and
// holds one entry behind a valid/ready handshake. It also keeps issue
// and stall counters for performance debug.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   in_valid / in_ready        decode-side handshake
//   rs/rt/rd_addr, rs/rt_data  register numbers and register-file read data
//   imm16, imm_zext, alu_src   immediate and operand-B select
//   alu_op, funct              ALU operation class and R-type function
//   exmem_*, memwb_*           forwarding sources
//   flush                      squash the held entry
//   A_in, B_in, ALU_ctrl,
//   out_rd, illegal_op         registered entry for the EX stage
//   out_valid / out_ready      EX-side handshake
//   issue_cnt, stall_cnt       performance counters (wrap)
module alu_issue_stage #(
  parameter int DW = 32,
  parameter int RW = 5,
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [RW-1:0] rs_addr,
  input  logic [RW-1:0] rt_addr,
  input  logic [RW-1:0] rd_addr,
  input  logic [DW-1:0] rs_data,
  input  logic [DW-1:0] rt_data,
  input  logic [15:0]   imm16,
  input  logic          imm_zext,
  input  logic          alu_src,
  input  logic [1:0]    alu_op,
  input  logic [5:0]    funct,
  input  logic          exmem_wr_en,
  input  logic          memwb_wr_en,
  input  logic [RW-1:0] exmem_rd,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] exmem_data,
  input  logic [DW-1:0] memwb_data,
  input  logic          flush,
  output logic [DW-1:0] A_in,
  output logic [DW-1:0] B_in,
  output logic [3:0]    ALU_ctrl,
  output logic [RW-1:0] out_rd,
  output logic          illegal_op,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [CW-1:0] issue_cnt,
  output logic [CW-1:0] stall_cnt
);

  logic [DW-1:0] a_q, a_d;
  logic [DW-1:0] b_q, b_d;
  logic [3:0]    ctrl_q, ctrl_d;
  logic [RW-1:0] rd_q;
  logic          ill_q, ill_d;
  logic          valid_q;
  logic [CW-1:0] issue_q, stall_q;

  logic [DW-1:0] fwd_rs, fwd_rt, imm_ext;
  logic          accept;

  // EX/MEM wins over MEM/WB; register 0 is hard-wired and never forwarded.
  function automatic logic [DW-1:0] forward(input logic [RW-1:0] addr,
                                            input logic [DW-1:0] rf_data);
    if (exmem_wr_en && exmem_rd == addr && addr != '0)
      return exmem_data;
    else if (memwb_wr_en && memwb_rd == addr && addr != '0)
      return memwb_data;
    else
      return rf_data;
  endfunction

  always_comb begin
    fwd_rs  = forward(rs_addr, rs_data);
    fwd_rt  = forward(rt_addr, rt_data);
    imm_ext = imm_zext ? DW'(imm16) : DW'($signed(imm16));
    a_d     = fwd_rs;
    b_d     = alu_src ? imm_ext : fwd_rt;
  end

  always_comb begin
    ctrl_d = 4'b0010;
    ill_d  = 1'b0;
    unique case (alu_op)
      2'b00: ctrl_d = 4'b0010;
      2'b01: ctrl_d = 4'b0110;
      2'b11: ctrl_d = 4'b1111;
      default: begin
        case (funct)
          6'b100000: ctrl_d = 4'b0010;
          6'b100010: ctrl_d = 4'b0110;
          6'b100100: ctrl_d = 4'b0000;
          6'b100101: ctrl_d = 4'b0001;
          6'b100111: ctrl_d = 4'b1100;
          6'b101010: ctrl_d = 4'b0111;
          default:   ill_d  = 1'b1;
        endcase
      end
    endcase
  end

  // Flush blocks capture so a squashed cycle never loads a new entry.
  assign in_ready = (~valid_q | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      ctrl_q  <= 4'b0010;
      rd_q    <= '0;
      ill_q   <= 1'b0;
      issue_q <= '0;
      stall_q <= '0;
    end else begin
      if (accept) begin
        valid_q <= 1'b1;
        a_q     <= a_d;
        b_q     <= b_d;
        ctrl_q  <= ctrl_d;
        rd_q    <= rd_addr;
        ill_q   <= ill_d;
      end else if (flush || out_ready) begin
        valid_q <= 1'b0;
      end
      if (valid_q && out_ready) issue_q <= issue_q + 1'b1;
      if (in_valid && !in_ready) stall_q <= stall_q + 1'b1;
    end
  end

  assign A_in       = a_q;
  assign B_in       = b_q;
  assign ALU_ctrl   = ctrl_q;
  assign out_rd     = rd_q;
  assign illegal_op = ill_q;
  assign out_valid  = valid_q;
  assign issue_cnt  = issue_q;
  assign stall_cnt  = stall_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid, in_ready;
  logic [RW-1:0] rs_addr, rt_addr, rd_addr;
  logic [DW-1:0] rs_data, rt_data;
  logic [15:0]   imm16;
  logic          imm_zext, alu_src;
  logic [1:0]    alu_op;
  logic [5:0]    funct;
  logic          exmem_wr_en, memwb_wr_en;
  logic [RW-1:0] exmem_rd, memwb_rd;
  logic [DW-1:0] exmem_data, memwb_data;
  logic          flush;
  logic [DW-1:0] A_in, B_in;
  logic [3:0]    ALU_ctrl;
  logic [RW-1:0] out_rd;
  logic          illegal_op, out_valid, out_ready;
  logic [CW-1:0] issue_cnt, stall_cnt;

  alu_issue_stage #(.DW(DW), .RW(RW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .rs_data(rs_data), .rt_data(rt_data), .imm16(imm16),
    .imm_zext(imm_zext), .alu_src(alu_src), .alu_op(alu_op), .funct(funct),
    .exmem_wr_en(exmem_wr_en), .memwb_wr_en(memwb_wr_en),
    .exmem_rd(exmem_rd), .memwb_rd(memwb_rd),
    .exmem_data(exmem_data), .memwb_data(memwb_data), .flush(flush),
    .A_in(A_in), .B_in(B_in), .ALU_ctrl(ALU_ctrl), .out_rd(out_rd),
    .illegal_op(illegal_op), .out_valid(out_valid), .out_ready(out_ready),
    .issue_cnt(issue_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit checking = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    bit            valid;
    logic [DW-1:0] a, b;
    logic [3:0]    ctrl;
    logic [RW-1:0] rd;
    bit            ill;
  } entry_t;

  entry_t        m;
  logic [CW-1:0] m_issue, m_stall;

  function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] addr, input logic [DW-1:0] rf);
    if (addr == 0) return rf;
    if (exmem_wr_en && exmem_rd == addr) return exmem_data;
    if (memwb_wr_en && memwb_rd == addr) return memwb_data;
    return rf;
  endfunction

  function automatic logic [DW-1:0] ref_imm();
    logic [DW-1:0] v;
    v = {16'h0, imm16};
    if (!imm_zext && imm16[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  // returns {illegal, ctrl}
  function automatic logic [4:0] ref_ctrl(input logic [1:0] op, input logic [5:0] f);
    if (op == 2'd0) return 5'h02;
    if (op == 2'd1) return 5'h06;
    if (op == 2'd3) return 5'h0F;
    case (f)
      6'd32: return 5'h02;
      6'd34: return 5'h06;
      6'd36: return 5'h00;
      6'd37: return 5'h01;
      6'd39: return 5'h0C;
      6'd42: return 5'h07;
      default: return 5'h12;
    endcase
  endfunction

  function automatic bit ref_in_ready();
    return (!m.valid || out_ready) && !flush;
  endfunction

  always @(posedge clk) begin
    entry_t        nx;
    logic [4:0]    c;
    nx = m;
    if (reset) begin
      nx.valid = 0; nx.a = 0; nx.b = 0; nx.ctrl = 4'b0010; nx.rd = 0; nx.ill = 0;
      m_issue <= 0;
      m_stall <= 0;
    end else begin
      if (m.valid && out_ready) m_issue <= m_issue + 1;
      if (in_valid && !ref_in_ready()) m_stall <= m_stall + 1;
      if (in_valid && ref_in_ready()) begin
        c = ref_ctrl(alu_op, funct);
        nx.valid = 1;
        nx.a     = ref_fwd(rs_addr, rs_data);
        nx.b     = alu_src ? ref_imm() : ref_fwd(rt_addr, rt_data);
        nx.ctrl  = c[3:0];
        nx.ill   = c[4];
        nx.rd    = rd_addr;
      end else if (m.valid && (out_ready || flush)) begin
        nx.valid = 0;
      end
    end
    m <= nx;
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("in_ready", in_ready, ref_in_ready());
      chk("out_valid", out_valid, m.valid);
      chk("issue_cnt", issue_cnt, m_issue);
      chk("stall_cnt", stall_cnt, m_stall);
      if (m.valid) begin
        chk("A_in", A_in, m.a);
        chk("B_in", B_in, m.b);
        chk("ALU_ctrl", ALU_ctrl, m.ctrl);
        chk("out_rd", out_rd, m.rd);
        chk("illegal_op", illegal_op, m.ill);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid = 0; rs_addr = 1; rt_addr = 2; rd_addr = 3;
    rs_data = 0; rt_data = 0; imm16 = 0; imm_zext = 0; alu_src = 0;
    alu_op = 0; funct = 0; exmem_wr_en = 0; memwb_wr_en = 0;
    exmem_rd = 0; memwb_rd = 0; exmem_data = 0; memwb_data = 0;
    flush = 0; out_ready = 1;
  endtask

  localparam logic [5:0] FUNCTS [8] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42, 6'd7, 6'd0};

  initial begin
    idle_inputs();
    reset = 1;
    cyc(); cyc();
    checking = 1;
    chk("rst out_valid", out_valid, 0);
    chk("rst A_in", A_in, 0);
    chk("rst ALU_ctrl", ALU_ctrl, 4'b0010);
    chk("rst issue_cnt", issue_cnt, 0);
    chk("rst stall_cnt", stall_cnt, 0);
    reset = 0;

    // R-type subtract
    alu_op = 2'b10; funct = 6'b100010; rs_data = 7; rt_data = 3; in_valid = 1;
    cyc();
    in_valid = 0;
    chk("sub out_valid", out_valid, 1);
    chk("sub A_in", A_in, 7);
    chk("sub B_in", B_in, 3);
    chk("sub ALU_ctrl", ALU_ctrl, 4'b0110);
    cyc();
    chk("sub issue_cnt", issue_cnt, 1);

    // forwarding priority
    exmem_wr_en = 1; exmem_rd = 5; exmem_data = 32'hAAAA_0000;
    memwb_wr_en = 1; memwb_rd = 5; memwb_data = 32'h0000_1234;
    rs_addr = 5; rt_addr = 5; alu_op = 0; in_valid = 1;
    cyc();
    chk("fwd A_in", A_in, 32'hAAAA_0000);
    chk("fwd B_in", B_in, 32'hAAAA_0000);
    rs_addr = 0; rs_data = 32'h55;
    cyc();
    chk("r0 A_in", A_in, 32'h55);
    exmem_wr_en = 0; memwb_wr_en = 0;

    // immediate extension
    alu_src = 1; imm16 = 16'h8001; imm_zext = 0;
    cyc();
    chk("sext B_in", B_in, 32'hFFFF_8001);
    imm_zext = 1;
    cyc();
    chk("zext B_in", B_in, 32'h0000_8001);

    // back-pressure for 3 cycles
    out_ready = 0; rs_data = 32'h99;
    cyc(); cyc(); cyc();
    chk("stall in_ready", in_ready, 0);
    chk("stall A_in held", A_in, 32'h55);
    chk("stall stall_cnt", stall_cnt, 3);
    out_ready = 1;
    cyc();
    chk("resume A_in", A_in, 32'h99);
    chk("resume out_valid", out_valid, 1);

    // flush with a held entry
    out_ready = 0; flush = 1;
    cyc();
    chk("flush out_valid", out_valid, 0);
    chk("flush stall_cnt", stall_cnt, 4);
    flush = 0; out_ready = 1;

    // illegal funct, then compare op
    alu_src = 0; alu_op = 2'b10; funct = 6'b000111;
    cyc();
    chk("ill ALU_ctrl", ALU_ctrl, 4'b0010);
    chk("ill illegal_op", illegal_op, 1);
    alu_op = 2'b11;
    cyc();
    chk("eq ALU_ctrl", ALU_ctrl, 4'b1111);
    chk("eq illegal_op", illegal_op, 0);

    // reset mid-stream
    reset = 1;
    cyc();
    chk("rst2 out_valid", out_valid, 0);
    chk("rst2 B_in", B_in, 0);
    chk("rst2 issue_cnt", issue_cnt, 0);
    chk("rst2 stall_cnt", stall_cnt, 0);
    reset = 0;

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 2) != 0);
      flush       = ($urandom_range(0, 15) == 0);
      reset       = ($urandom_range(0, 199) == 0);
      rs_addr     = RW'($urandom_range(0, 3));
      rt_addr     = RW'($urandom_range(0, 3));
      rd_addr     = RW'($urandom);
      rs_data     = $urandom;
      rt_data     = $urandom;
      imm16       = 16'($urandom);
      imm_zext    = 1'($urandom);
      alu_src     = 1'($urandom);
      alu_op      = 2'($urandom);
      funct       = ($urandom_range(0, 3) == 0) ? 6'($urandom) : FUNCTS[$urandom_range(0, 7)];
      exmem_wr_en = 1'($urandom);
      memwb_wr_en = 1'($urandom);
      exmem_rd    = RW'($urandom_range(0, 3));
      memwb_rd    = RW'($urandom_range(0, 3));
      exmem_data  = $urandom;
      memwb_data  = $urandom;
      cyc();
    end

    idle_inputs();
    reset = 0;
    cyc(); cyc();
    checking = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX pipeline stage directly upstream of the 32-bit ALU.
- Accepts decoded instructions from decode and resolves operands, applying EX/MEM and MEM/WB forwarding and immediate extension/selection.
- Decodes the 4-bit ALU control code and registers A_in, B_in and ALU_ctrl for the ALU behind a one-entry valid/ready pipeline register.
- Also keeps issue and stall counters for performance debug.

Parameters:
- DW, 32, operand/data width.
- RW, 5, register-address width.
- CW, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  decode holds a valid instruction.
- in_ready  out  1  stage can accept this cycle.
- rs_addr, rt_addr, rd_addr  in  RW each  source and destination register numbers.
- rs_data, rt_data  in  DW each  register-file read data.
- imm16  in  16  instruction immediate.
- imm_zext  in  1  1 = zero-extend imm16, 0 = sign-extend.
- alu_src  in  1  1 = B operand is the immediate, 0 = forwarded rt.
- alu_op  in  2  00 add, 01 sub, 10 R-type (use funct), 11 equal-compare.
- funct  in  6  R-type function field.
- exmem_wr_en, memwb_wr_en  in  1 each  forwarding source writes a register.
- exmem_rd, memwb_rd  in  RW each  forwarding destination numbers.
- exmem_data, memwb_data  in  DW each  forwarding values.
- flush  in  1  squash the held entry (branch/exception).
- A_in, B_in  out  DW each  registered ALU operands.
- ALU_ctrl  out  4  registered ALU selection.
- out_rd  out  RW  registered destination number.
- illegal_op  out  1  registered: R-type funct not supported.
- out_valid  out  1  A_in/B_in/ALU_ctrl/out_rd/illegal_op are valid.
- out_ready  in  1  EX stage consumes the entry this cycle.
- issue_cnt  out  CW  entries transferred out (out_valid & out_ready).
- stall_cnt  out  CW  cycles with in_valid & ~in_ready.

Behaviour:
- Reset (sync, clk edge with reset=1):
  - out_valid=0, A_in=0, B_in=0, ALU_ctrl=4'b0010, out_rd=0, illegal_op=0, issue_cnt=0, stall_cnt=0.
  - Reset overrides flush and all handshakes, including mid-transfer.
- Handshake:
  - in_ready = (~out_valid | out_ready) & ~flush, combinational.
  - Accept = in_valid & in_ready. On accept, all output registers load next edge and out_valid=1.
  - If out_valid & out_ready & no accept, out_valid←0.
  - If out_valid & ~out_ready, all outputs hold stable.
  - Latency: one cycle from accept to out_valid.
  - Back-to-back acceptance at full throughput when out_ready=1.
- Flush:
  - Next edge out_valid←0; no new capture that cycle (in_ready=0).
  - Counters are unaffected except that stall_cnt counts the cycle if in_valid=1.
- Forwarding (evaluated combinationally at accept; captured values are not re-forwarded while held):
  - Applied to rs and rt independently.
  - If exmem_wr_en & exmem_rd==addr & addr!=0, use exmem_data.
  - Else if memwb_wr_en & memwb_rd==addr & addr!=0, use memwb_data.
  - Else use the register-file data.
  - EX/MEM has priority over MEM/WB. Register 0 is never forwarded.
- Immediate: imm = imm_zext ? {16'b0, imm16} : {{16{imm16[15]}}, imm16}.
- Operands: A_in ← fwd_rs. B_in ← alu_src ? imm : fwd_rt.
- ALU_ctrl decode:
  - alu_op 00 → 0010. alu_op 01 → 0110. alu_op 11 → 1111.
  - alu_op 10, by funct: 100000→0010, 100010→0110, 100100→0000, 100101→0001, 100111→1100, 101010→0111.
  - Any other funct gives 0010 with illegal_op=1. illegal_op=0 in every other case.
- Counters:
  - issue_cnt += 1 on out_valid & out_ready. stall_cnt += 1 on in_valid & ~in_ready.
  - Both wrap modulo 2^CW with no saturation.
  - Both increment in the same cycle when both conditions hold.

Test Plan:
- Reset, then alu_op=10, funct=100010, rs_data=7, rt_data=3, no forwarding, out_ready=1 → next cycle out_valid=1, A_in=7, B_in=3, ALU_ctrl=0110, issue_cnt=1 one cycle later.
- exmem_wr_en=1, exmem_rd=5 (data 0xAAAA0000) and memwb_wr_en=1, memwb_rd=5 (data 0x1234) with rs_addr=rt_addr=5 → A_in=B_in=0xAAAA0000. Repeat with rs_addr=0 → A_in=rs_data.
- alu_src=1, imm16=0x8001 with imm_zext=0 → B_in=0xFFFF8001. With imm_zext=1 → B_in=0x00008001.
- out_ready=0 for 3 cycles while in_valid=1 → in_ready=0, outputs stable, stall_cnt=3. Raise out_ready → next entry loads one cycle later.
- flush asserted with out_valid=1 → out_valid=0 next edge and no capture. Assert reset while in_valid=1 → all outputs take reset values.
- alu_op=10, funct=000111 → ALU_ctrl=0010, illegal_op=1. Then alu_op=11 → ALU_ctrl=1111, illegal_op=0.
